// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//
// Word-addressed memory responder for the datapath memory port. It captures
// one request (address, write data, read/write op) and counts WAIT_CYCLES wait
// states. It then performs the access and holds `ready` until both strobes
// are low again, which is a four-phase level handshake.
//
// Handshake: a request is accepted on any edge in IDLE where Read|Write is
// high. Later strobe changes are ignored until the access completes. `ready`
// then stays high, with data_out/err stable, until an edge sees both strobes
// low. The FSM returns to IDLE on that edge, so a held strobe is serviced once.
//
// Optional feature macro: MEM_RESPONDER_WRITE_PROTECT_EN
//   When defined, writes to addresses below PROTECT_LIMIT complete the
//   handshake normally but leave the array unchanged, and `err` is raised
//   for the whole DONE state. When undefined, `err` is always 0.
//
// Parameters:
//   ADDR_W        address width, depth = 2**ADDR_W 32-bit words
//   WAIT_CYCLES   wait states between capture and access (0..15)
//   PROTECT_LIMIT lowest writable address when protection is compiled in
//
// Ports:
//   clk       clock, rising edge
//   clr       synchronous active-high reset
//   Read      read request strobe (level)
//   Write     write request strobe (level, wins over Read)
//   address   word address from MAR
//   data_in   write data from MDR
//   data_out  read data to MDR (holds the last read value)
//   ready     access complete
//   busy      high in WAIT and DONE
//   err       protected write rejected, valid while ready is high
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int ADDR_W        = 9,
  parameter int WAIT_CYCLES   = 2,
  parameter int PROTECT_LIMIT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              Read,
  input  logic              Write,
  input  logic [ADDR_W-1:0] address,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state;
  logic [3:0]        wait_cnt;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              op_write;
  logic              do_access;
  logic              blocked;

  // Storage array, intentionally not cleared by reset.
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  assign do_access = (state == S_WAIT) && (wait_cnt == 4'd0);

`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
  localparam int unsigned LIMIT_U = PROTECT_LIMIT;
  assign blocked = op_write && (32'(addr_q) < LIMIT_U);
`else
  logic unused_limit;
  assign unused_limit = (PROTECT_LIMIT != 0);
  assign blocked      = 1'b0;
`endif

  // Array write port. The commit is gated by clr, so a write that is still
  // waiting when reset arrives never reaches the array.
  always_ff @(posedge clk) begin
    if (!clr && do_access && op_write && !blocked) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
      op_write <= 1'b0;
      data_out <= 32'd0;
      ready    <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (Read || Write) begin
            addr_q   <= address;
            wdata_q  <= data_in;
            op_write <= Write;
            wait_cnt <= 4'(WAIT_CYCLES);
            busy     <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
          end else begin
            // Writes leave data_out untouched so it keeps the last read value.
            if (!op_write) begin
              data_out <= mem[addr_q];
            end
            ready <= 1'b1;
            err   <= blocked;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // Leave only once both strobes are low, so a held strobe gets a
          // single service.
          if (!(Read || Write)) begin
            ready <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//
// Bench for mem_responder. The main instance uses the default parameters
// (ADDR_W=9, WAIT_CYCLES=2). A second instance uses WAIT_CYCLES=0 for the
// zero-wait latency case. The driver pushes expected responses for the main
// instance into queues, and a monitor pops and compares them whenever `ready`
// rises. Expectations follow MEM_RESPONDER_WRITE_PROTECT_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int ADDR_W = 9;
  localparam int WAITS  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (WAIT_CYCLES=2) ----------------
  logic              rd = 1'b0, wr = 1'b0;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       din = 32'd0;
  logic [31:0]       dout;
  logic              ready, busy, err;

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAITS), .PROTECT_LIMIT(16)) dut (
    .clk(clk), .clr(clr), .Read(rd), .Write(wr), .address(addr),
    .data_in(din), .data_out(dout), .ready(ready), .busy(busy), .err(err)
  );

  // ---------------- zero-wait DUT ----------------
  logic              rd0 = 1'b0, wr0 = 1'b0;
  logic [ADDR_W-1:0] addr0 = '0;
  logic [31:0]       din0 = 32'd0;
  logic [31:0]       dout0;
  logic              ready0, busy0, err0;

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0), .PROTECT_LIMIT(16)) dut0 (
    .clk(clk), .clr(clr), .Read(rd0), .Write(wr0), .address(addr0),
    .data_in(din0), .data_out(dout0), .ready(ready0), .busy(busy0), .err(err0)
  );

  // ---------------- checking ----------------
  int total = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  // Scoreboard queues for the main instance.
  logic [31:0] exp_q[$];
  logic [31:0] exp_err_q[$];
  int          exp_cyc_q[$];

  // Reference model state.
  logic [31:0] model [0:(1<<ADDR_W)-1];
  logic [31:0] last_read = 32'd0;

  function automatic logic is_protected(input logic [ADDR_W-1:0] a);
`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
    return (a < 16);
`else
    return (a != a);
`endif
  endfunction

  // Monitor: every rising edge of ready must match one queued response.
  logic ready_prev = 1'b0;
  always @(negedge clk) begin
    if (ready && !ready_prev) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        check("data_out", dout, exp_q.pop_front());
        check("err", 32'(err), exp_err_q.pop_front());
        check("ready_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
      end
    end
    ready_prev = ready;
  end

  // ---------------- driver ----------------
  // Drives one request, waits for ready, keeps the strobes for `hold` extra
  // cycles, then releases them and checks that the handshake closes.
  task automatic access(input logic r, input logic w, input logic [ADDR_W-1:0] a,
                        input logic [31:0] d, input int hold);
    int n;
    @(negedge clk);
    rd = r; wr = w; addr = a; din = d;
    if (w) begin
      exp_q.push_back(last_read);
      exp_err_q.push_back(32'(is_protected(a)));
      if (!is_protected(a)) model[a] = d;
    end else begin
      last_read = model[a];
      exp_q.push_back(last_read);
      exp_err_q.push_back(32'd0);
    end
    // Request edge is cyc+1; ready is visible after edge cyc+1+1+WAITS.
    exp_cyc_q.push_back(cyc + 2 + WAITS);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
    if (!ready) check("ready_timeout", 32'(ready), 32'd1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("ready_held", 32'(ready), 32'd1);
    end
    rd = 1'b0; wr = 1'b0;
    @(negedge clk);
    check("ready_release", 32'(ready), 32'd0);
    check("busy_release", 32'(busy), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Watchdog against a hung handshake.
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_data_out", dout, 32'd0);
    check("rst_ready", 32'(ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    clr = 1'b0;

    // Seed locations used later.
    access(1'b0, 1'b1, 9'd0,  32'h1111_1111, 0);
    access(1'b0, 1'b1, 9'd20, 32'h0000_0020, 0);

    // Write then read back.
    access(1'b0, 1'b1, 9'd9, 32'h0000_0074, 0);
    access(1'b1, 1'b0, 9'd9, 32'h0, 0);

    // Both strobes: the write wins and data_out keeps 0x74.
    access(1'b1, 1'b1, 9'd5, 32'hA100_0000, 0);
    access(1'b1, 1'b0, 9'd5, 32'h0, 2);

    // Reset while a write of 0xDEADBEEF to addr 20 is waiting.
    @(negedge clk);
    wr = 1'b1; addr = 9'd20; din = 32'hDEAD_BEEF;
    @(negedge clk);
    check("midwr_busy", 32'(busy), 32'd1);
    clr = 1'b1;
    @(negedge clk);
    check("midrst_data_out", dout, 32'd0);
    check("midrst_ready", 32'(ready), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_err", 32'(err), 32'd0);
    clr = 1'b0; wr = 1'b0;
    last_read = 32'd0;
    access(1'b1, 1'b0, 9'd20, 32'h0, 0);

    // Protection (or a plain write when the feature is not built in).
`ifdef MEM_RESPONDER_WRITE_PROTECT_EN
    dut.mem[3] = 32'h0000_0033;
    model[3]   = 32'h0000_0033;
`else
    access(1'b0, 1'b1, 9'd3, 32'h0000_0033, 0);
`endif
    access(1'b0, 1'b1, 9'd3,  32'h1234_5678, 0);
    access(1'b1, 1'b0, 9'd3,  32'h0, 0);
    access(1'b0, 1'b1, 9'd16, 32'h1234_5678, 0);
    access(1'b1, 1'b0, 9'd16, 32'h0, 0);

    // Top of the address range; addr 0 keeps its seed value.
    access(1'b0, 1'b1, 9'd511, 32'h0000_0067, 0);
    access(1'b1, 1'b0, 9'd511, 32'h0, 0);
    access(1'b1, 1'b0, 9'd0,   32'h0, 0);

    // Zero-wait instance: seed addr 7, then hold Read for several cycles.
    @(negedge clk);
    wr0 = 1'b1; addr0 = 9'd7; din0 = 32'h5A5A_0007;
    @(negedge clk);
    check("zw_wr_not_early", 32'(ready0), 32'd0);
    @(negedge clk);
    check("zw_wr_ready", 32'(ready0), 32'd1);
    wr0 = 1'b0;
    @(negedge clk);
    check("zw_wr_release", 32'(ready0), 32'd0);
    rd0 = 1'b1;
    @(negedge clk);
    check("zw_rd_not_early", 32'(ready0), 32'd0);
    @(negedge clk);
    check("zw_rd_ready", 32'(ready0), 32'd1);
    check("zw_rd_data", dout0, 32'h5A5A_0007);
    check("zw_rd_err", 32'(err0), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("zw_single_access", 32'(ready0), 32'd1);
    end
    rd0 = 1'b0;
    @(negedge clk);
    check("zw_release_ready", 32'(ready0), 32'd0);
    check("zw_release_busy", 32'(busy0), 32'd0);
    check("zw_data_hold", dout0, 32'h5A5A_0007);

    repeat (3) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
